clkdiv_prog: RTL and testbench

Programmable clock divider: the parametrised successor to the fixed divide-by-5 and divide-by-25 dividers in the SPDIF-to-I2S clock tree. It derives bit and frame clocks from the recovered/master clock. It has two modes: an integer mode with a runtime divisor and glitch-free reprogramming, and a fractional mode built on a phase accumulator for non-integer ratios. Both clk_out and a one-cycle tick strobe are registered. Downstream logic uses the tick as a clock enable, so it can stay in the clk_in domain.

---
 rtl/clkdiv_prog_if.sv | 34 +++
 rtl/clkdiv_prog.sv | 114 +++++++++++
 tb/tb_clkdiv_prog.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_prog_if.sv
// clkdiv_prog_if
//   Groups the control and status signals of the programmable clock divider.
//   master : the controller that programs the divider and observes its outputs
//   slave  : the divider itself
// Signals
//   div        requested integer divisor
//   div_load   one-cycle strobe that captures div
//   frac_en    0 = integer mode, 1 = fractional (phase accumulator) mode
//   frac_inc   phase increment per clock in fractional mode
//   clk_out    divided clock (registered)
//   tick       one-cycle strobe in the cycle before each clk_out rising edge
//   div_active divisor currently in effect
interface clkdiv_prog_if #(
   parameter int DIV_W  = 8,
   parameter int FRAC_W = 16
);
   logic [DIV_W-1:0]  div;
   logic              div_load;
   logic              frac_en;
   logic [FRAC_W-1:0] frac_inc;
   logic              clk_out;
   logic              tick;
   logic [DIV_W-1:0]  div_active;

   modport master (
      output div, div_load, frac_en, frac_inc,
      input  clk_out, tick, div_active
   );

   modport slave (
      input  div, div_load, frac_en, frac_inc,
      output clk_out, tick, div_active
   );
endinterface

// File: rtl/clkdiv_prog.sv
// clkdiv_prog
//   Programmable clock divider for the SPDIF-to-I2S clock tree. Integer mode
//   divides clk_in by a runtime divisor that is only swapped at a period
//   boundary, so clk_out never glitches. Fractional mode uses a phase
//   accumulator for non-integer ratios. clk_out and tick are both registered;
//   downstream logic uses tick as a clock enable in the clk_in domain.
// Ports
//   clk_in  sole clock, rising edge
//   reset   synchronous, active-high reset
//   bus     clkdiv_prog_if.slave (div, div_load, frac_en, frac_inc in;
//           clk_out, tick, div_active out)
module clkdiv_prog #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 5,
   parameter int FRAC_W      = 16
) (
   input  logic          clk_in,
   input  logic          reset,
   clkdiv_prog_if.slave  bus
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

   logic [DIV_W-1:0]  cnt_reg;
   logic [DIV_W-1:0]  div_active_reg;
   logic [DIV_W-1:0]  pend_reg;
   logic              pend_valid_reg;
   logic              frac_en_q_reg;
   logic              clk_out_reg;
   logic              tick_reg;
   logic [FRAC_W-1:0] acc_reg;

   logic [DIV_W-1:0]  div_clamped;
   logic [DIV_W-1:0]  last_cnt;
   logic [DIV_W-1:0]  half_cnt;
   logic              boundary;
   logic              mode_switch;
   logic [FRAC_W:0]   acc_sum;

   // Divisors 0 and 1 cannot produce a clock; they are raised to 2.
   assign div_clamped = (bus.div < MIN_DIV) ? MIN_DIV : bus.div;
   assign last_cnt    = div_active_reg - 1'b1;
   // High phase is floor(N/2); odd divisors give the extra cycle to the low phase.
   assign half_cnt    = div_active_reg >> 1;
   assign boundary    = (cnt_reg == last_cnt);
   assign mode_switch = (bus.frac_en != frac_en_q_reg);
   // Extra MSB of the sum is the accumulator carry, i.e. the fractional tick.
   assign acc_sum     = {1'b0, acc_reg} + {1'b0, bus.frac_inc};

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_reg        <= '0;
         acc_reg        <= '0;
         clk_out_reg    <= 1'b0;
         tick_reg       <= 1'b0;
         div_active_reg <= DEF_DIV;
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
         frac_en_q_reg  <= 1'b0;
      end else if (mode_switch) begin
         // One quiet cycle, then the new mode starts from phase 0.
         cnt_reg       <= '0;
         acc_reg       <= '0;
         clk_out_reg   <= 1'b0;
         tick_reg      <= 1'b0;
         frac_en_q_reg <= bus.frac_en;
         if (pend_valid_reg) begin
            div_active_reg <= pend_reg;
         end
         // A load coinciding with the switch is kept for the next boundary.
         if (bus.div_load) begin
            pend_reg       <= div_clamped;
            pend_valid_reg <= 1'b1;
         end else begin
            pend_valid_reg <= 1'b0;
         end
      end else if (!frac_en_q_reg) begin
         clk_out_reg <= (cnt_reg < half_cnt);
         tick_reg    <= boundary;
         if (boundary) begin
            cnt_reg <= '0;
            // A load on the boundary itself wins over any older pending value.
            if (bus.div_load) begin
               div_active_reg <= div_clamped;
               pend_valid_reg <= 1'b0;
            end else if (pend_valid_reg) begin
               div_active_reg <= pend_reg;
               pend_valid_reg <= 1'b0;
            end
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (bus.div_load) begin
               pend_reg       <= div_clamped;
               pend_valid_reg <= 1'b1;
            end
         end
      end else begin
         acc_reg     <= acc_sum[FRAC_W-1:0];
         clk_out_reg <= acc_sum[FRAC_W-1];
         tick_reg    <= acc_sum[FRAC_W];
         // div_active is frozen in fractional mode; loads wait in pending.
         if (bus.div_load) begin
            pend_reg       <= div_clamped;
            pend_valid_reg <= 1'b1;
         end
      end
   end

   assign bus.clk_out    = clk_out_reg;
   assign bus.tick       = tick_reg;
   assign bus.div_active = div_active_reg;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog
//   Self-checking bench for clkdiv_prog: a table of reset/startup vectors,
//   hand-written sequences for reprogramming, clamping, fractional mode and
//   reset corners, then randomized stimulus against a period-level model.
module tb_clkdiv_prog;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;

   always #5 clk_in = ~clk_in;

   clkdiv_prog_if #(.DIV_W(8), .FRAC_W(16)) bus ();

   clkdiv_prog #(.DIV_W(8), .DEFAULT_DIV(5), .FRAC_W(16)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   // Integer mode: a whole period of expected outputs is queued at once from
   // the divisor in effect; the edge that pops the last entry is the boundary.
   // Fractional mode: a running total of increments; tick when the 2^16
   // multiple count advances, clk_out is bit 15 of the total.
   bit      m_frac;
   int      m_active;
   bit      m_pend_v;
   int      m_pend;
   bit      clk_q[$];
   bit      tick_q[$];
   longint  m_total;
   bit      exp_clk;
   bit      exp_tick;
   logic    cur_fe = 1'b0;
   logic [15:0] cur_fi = 16'h0;

   function automatic int clamp(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   task automatic model_step(input logic r, input logic dl, input int d,
                             input logic fe, input int fi);
      longint old;
      if (r) begin
         exp_clk = 0; exp_tick = 0;
         m_active = 5; m_pend_v = 0; m_frac = 0;
         clk_q.delete(); tick_q.delete(); m_total = 0;
      end else if (fe != m_frac) begin
         exp_clk = 0; exp_tick = 0;
         if (m_pend_v) m_active = m_pend;
         m_pend_v = 0;
         if (dl) begin m_pend = clamp(d); m_pend_v = 1; end
         m_frac = fe;
         clk_q.delete(); tick_q.delete(); m_total = 0;
      end else if (!m_frac) begin
         if (clk_q.size() == 0) begin
            for (int i = 0; i < m_active; i++) begin
               clk_q.push_back(i < m_active / 2);
               tick_q.push_back(i == m_active - 1);
            end
         end
         exp_clk  = clk_q.pop_front();
         exp_tick = tick_q.pop_front();
         if (clk_q.size() == 0) begin
            if (dl) begin m_active = clamp(d); m_pend_v = 0; end
            else if (m_pend_v) begin m_active = m_pend; m_pend_v = 0; end
         end else if (dl) begin
            m_pend = clamp(d); m_pend_v = 1;
         end
      end else begin
         old = m_total;
         m_total = m_total + fi;
         exp_tick = ((m_total >> 16) != (old >> 16));
         exp_clk  = m_total[15];
         if (dl) begin m_pend = clamp(d); m_pend_v = 1; end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: drive, advance, update model, compare outputs off the edge.
   task automatic cyc(input logic r, input logic dl, input logic [7:0] d,
                      input logic fe, input logic [15:0] fi);
      reset = r; bus.div_load = dl; bus.div = d; bus.frac_en = fe; bus.frac_inc = fi;
      cur_fe = fe; cur_fi = fi;
      @(posedge clk_in);
      model_step(r, dl, int'(d), fe, int'(fi));
      #1;
      chk("model", {bus.clk_out, bus.tick, bus.div_active},
          {exp_clk, exp_tick, 8'(m_active)});
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'd0, cur_fe, cur_fi);
   endtask

   // Advance until the next clock edge is an integer-mode period boundary.
   task automatic run_to_boundary();
      for (int k = 0; k < 600; k++) begin
         if (!m_frac && clk_q.size() == 1) return;
         idle();
      end
      chk("boundary_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      logic        r;
      logic        dl;
      logic [7:0]  d;
      logic        fe;
      logic [15:0] fi;
      logic        ec;
      logic        et;
      logic [7:0]  ea;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [9:0] cpat;
      logic [9:0] tpat;
      logic [7:0] cv, tv;
      int hi, tk, chg;
      logic c0;
      logic [7:0] d;
      logic r, dl, fe;
      logic [15:0] fi;

      bus.div = '0; bus.div_load = 1'b0; bus.frac_en = 1'b0; bus.frac_inc = '0;

      // ---- table: reset, then default divide-by-5 pattern ----
      cpat = 10'b1100011000;
      tpat = 10'b0000100001;
      for (int i = 0; i < 2; i++)
         tbl[i] = '{r:1'b1, dl:1'b0, d:8'd0, fe:1'b0, fi:16'h0, ec:1'b0, et:1'b0, ea:8'd5};
      for (int i = 0; i < 10; i++)
         tbl[i+2] = '{r:1'b0, dl:1'b0, d:8'd0, fe:1'b0, fi:16'h0,
                      ec:cpat[9-i], et:tpat[9-i], ea:8'd5};
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].r, tbl[i].dl, tbl[i].d, tbl[i].fe, tbl[i].fi);
         chk($sformatf("tbl%0d", i), {bus.clk_out, bus.tick, bus.div_active},
             {tbl[i].ec, tbl[i].et, tbl[i].ea});
      end

      // ---- div=8 loaded at cnt=2 of a div-5 period ----
      run_to_boundary(); idle();
      idle(); idle();
      cyc(1'b0, 1'b1, 8'd8, 1'b0, 16'h0);
      chk("load8_held_cnt2", bus.div_active, 8'd5);
      idle();
      chk("load8_held_cnt3", bus.div_active, 8'd5);
      idle();
      chk("load8_at_boundary", {bus.tick, bus.div_active}, {1'b1, 8'd8});
      for (int i = 0; i < 8; i++) begin
         idle(); cv = {cv[6:0], bus.clk_out}; tv = {tv[6:0], bus.tick};
      end
      chk("div8_clk", cv, 8'b11110000);
      chk("div8_tick", tv, 8'b00000001);

      // ---- clamping: 0, 1 and the maximum 255 ----
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd0, 1'b0, 16'h0);
      chk("clamp0", bus.div_active, 8'd2);
      for (int i = 0; i < 4; i++) begin
         idle(); cv = {cv[6:0], bus.clk_out}; tv = {tv[6:0], bus.tick};
      end
      chk("div2_clk", cv[3:0], 4'b1010);
      chk("div2_tick", tv[3:0], 4'b0101);
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd5, 1'b0, 16'h0);
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd1, 1'b0, 16'h0);
      chk("clamp1", bus.div_active, 8'd2);
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd255, 1'b0, 16'h0);
      chk("div255_active", bus.div_active, 8'd255);
      hi = 0; tk = 0;
      for (int i = 0; i < 255; i++) begin
         idle(); hi += int'(bus.clk_out); tk += int'(bus.tick);
      end
      chk("div255_high", hi, 127);
      chk("div255_ticks", tk, 1);

      // ---- two loads in one period, then a load on the boundary ----
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd5, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 8'd6, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 8'd9, 1'b0, 16'h0);
      chk("two_loads_held", bus.div_active, 8'd5);
      run_to_boundary(); idle();
      chk("two_loads_last_wins", bus.div_active, 8'd9);
      run_to_boundary();
      cyc(1'b0, 1'b1, 8'd3, 1'b0, 16'h0);
      chk("boundary_load", bus.div_active, 8'd3);

      // ---- fractional mode ----
      cyc(1'b0, 1'b0, 8'd0, 1'b1, 16'h4000);
      chk("frac_switch_gap", {bus.clk_out, bus.tick}, 2'b00);
      for (int i = 0; i < 8; i++) begin
         idle(); cv = {cv[6:0], bus.clk_out}; tv = {tv[6:0], bus.tick};
      end
      chk("frac4000_clk", cv, 8'b01100110);
      chk("frac4000_tick", tv, 8'b00010001);
      tk = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 8'd0, 1'b1, 16'h6000); tk += int'(bus.tick);
      end
      chk("frac6000_ticks", tk, 3);
      cyc(1'b0, 1'b0, 8'd0, 1'b1, 16'h0000);
      c0 = bus.clk_out; chg = 0; tk = int'(bus.tick);
      for (int i = 0; i < 7; i++) begin
         idle(); chg += int'(bus.clk_out != c0); tk += int'(bus.tick);
      end
      chk("frac0_static", {chg, tk}, 64'd0);
      cyc(1'b0, 1'b1, 8'd7, 1'b1, 16'h0000);
      chk("frac_load_held", bus.div_active, 8'd3);
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
      chk("int_switch_back", {bus.clk_out, bus.tick, bus.div_active}, {2'b00, 8'd7});
      for (int i = 0; i < 7; i++) begin
         idle(); cv = {cv[6:0], bus.clk_out};
      end
      chk("div7_clk", cv[6:0], 7'b1110000);

      // ---- reset mid-period with a pending divisor ----
      idle(); idle();
      cyc(1'b0, 1'b1, 8'd4, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 16'h0);
      chk("midreset", {bus.clk_out, bus.tick, bus.div_active}, {2'b00, 8'd5});
      for (int i = 0; i < 10; i++) begin
         idle(); cv = {cv[6:0], bus.clk_out}; tv = {tv[6:0], bus.tick};
         chk("midreset_active", bus.div_active, 8'd5);
      end
      chk("midreset_clk", cv[4:0], 5'b11000);
      chk("midreset_tick", tv[4:0], 5'b00001);

      // ---- randomized stimulus against the model ----
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(199) == 0);
         fe = ($urandom_range(99) == 0) ? ~cur_fe : cur_fe;
         fi = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(16'h7FFF));
         dl = ($urandom_range(7) == 0);
         if ($urandom_range(9) == 0) d = 8'($urandom_range(1));
         else if ($urandom_range(49) == 0) d = 8'($urandom_range(255, 40));
         else d = 8'($urandom_range(12, 2));
         cyc(r, dl, d, fe, fi);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
